axi_sram_bridge_mc: RTL and testbench

Parametrised sram-like-to-AXI3 bridge sitting between the dual-issue core's memory ports and the top-level AXI master. It generalises the single hard-wired test read path to NCH arbitrated read channels with burst support, plus one single-beat write channel with read-after-write ordering. One read and one write transaction may be in flight concurrently.

---
 rtl/axi_sram_bridge_mc.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_axi_sram_bridge_mc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_bridge_mc.sv
// Bridges NCH arbitrated sram-like read channels and one single-beat write
// channel onto an AXI3 master port, holding reads that hit a pending write page.
module axi_sram_bridge_mc #(
  parameter int NCH   = 2,
  parameter int LEN_W = 4,
  parameter int RR    = 1
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic [NCH-1:0]       rd_req,
  input  logic [NCH*32-1:0]    rd_addr,
  input  logic [NCH*LEN_W-1:0] rd_len,
  output logic [NCH-1:0]       rd_addr_ok,
  output logic [NCH-1:0]       rd_data_ok,
  output logic                 rd_last,
  output logic [31:0]          rd_rdata,
  input  logic                 wr_req,
  input  logic [31:0]          wr_addr,
  input  logic [1:0]           wr_size,
  input  logic [3:0]           wr_wstrb,
  input  logic [31:0]          wr_wdata,
  output logic                 wr_addr_ok,
  output logic                 wr_data_ok,
  output logic                 bus_err,
  output logic [3:0]           arid,
  output logic [31:0]          araddr,
  output logic [3:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic [1:0]           arlock,
  output logic [3:0]           arcache,
  output logic [2:0]           arprot,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [3:0]           rid,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [3:0]           awid,
  output logic [31:0]          awaddr,
  output logic [3:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic [1:0]           awlock,
  output logic [3:0]           awcache,
  output logic [2:0]           awprot,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [3:0]           wid,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [3:0]           bid,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, gnt_s;
  logic [31:0]   araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [31:0]   sel_addr_s;
  logic [LEN_W-1:0] sel_len_s;
  logic [LEN_W+3:0] len_ext_s;
  logic [3:0]    arlen_q, arlen_d, wstrb_q, wstrb_d;
  logic [2:0]    awsize_q, awsize_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [NCH-1:0] hazard_s, elig_s;
  logic          gnt_vld_s, rbeat_s, bbeat_s;
  logic          unused_s;

  // Read-after-write hazard: hold back reads aimed at the page being written.
  always_comb begin
    hazard_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_state_q != W_IDLE) begin
        hazard_s[i] = (rd_addr[32*i+12 +: 20] == awaddr_q[31:12]);
      end else if (wr_req) begin
        hazard_s[i] = (rd_addr[32*i+12 +: 20] == wr_addr[31:12]);
      end else begin
        hazard_s[i] = 1'b0;
      end
    end
    elig_s = rd_req & ~hazard_s;
  end

  // Arbiter: rank j visits channels from the RR pointer (or from 0), first eligible wins.
  always_comb begin
    gnt_vld_s  = 1'b0;
    gnt_s      = '0;
    sel_addr_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) begin
        if (!gnt_vld_s && elig_s[j] &&
            (j == ((RR != 0) ? ((int'(ptr_q) + i) % NCH) : i))) begin
          gnt_vld_s  = 1'b1;
          gnt_s      = GW'(j);
          sel_addr_s = rd_addr[32*j +: 32];
          sel_len_s  = rd_len[LEN_W*j +: LEN_W];
        end else begin
          gnt_vld_s  = gnt_vld_s;
        end
      end
    end
    len_ext_s = {4'b0000, sel_len_s};
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    case (rd_state_q)
      R_IDLE: begin
        if (gnt_vld_s) begin
          rd_state_d = R_AR;
          gnt_d      = gnt_s;
          ptr_d      = (gnt_s == GW'(NCH - 1)) ? '0 : gnt_s + GW'(1);
          araddr_d   = sel_addr_s;
          arlen_d    = len_ext_s[3:0];
          arvalid_d  = 1'b1;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_AR: begin
        if (arready) begin
          rd_state_d = R_DATA;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
        end else begin
          rd_state_d = R_AR;
        end
      end
      R_DATA: begin
        if (rvalid && rlast) begin
          rd_state_d = R_IDLE;
          rready_d   = 1'b0;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
      end
    endcase
  end

  // Write FSM next state; AW and W channels retire independently.
  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    awsize_d   = awsize_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req) begin
          wr_state_d = W_SEND;
          awaddr_d   = wr_addr;
          awsize_d   = {1'b0, wr_size};
          wstrb_d    = wr_wstrb;
          wdata_d    = wr_wdata;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_SEND: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          wr_state_d = W_RESP;
          bready_d   = 1'b1;
        end else begin
          wr_state_d = W_SEND;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          wr_state_d = W_IDLE;
          bready_d   = 1'b0;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        bready_d   = 1'b0;
      end
    endcase
  end

  // State and registered AXI request signals.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      araddr_q   <= 32'h0000_0000;
      arlen_q    <= 4'h0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= 32'h0000_0000;
      awsize_q   <= 3'd0;
      wstrb_q    <= 4'h0;
      wdata_q    <= 32'h0000_0000;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
    end
  end

  assign rbeat_s = (rd_state_q == R_DATA) && rvalid && !reset;
  assign bbeat_s = (wr_state_q == W_RESP) && bvalid && !reset;

  // Per-channel handshakes toward the core; beats follow the latched grant.
  always_comb begin
    rd_addr_ok = '0;
    rd_data_ok = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_addr_ok[i] = (rd_state_q == R_IDLE) && gnt_vld_s && !reset && (gnt_s == GW'(i));
      rd_data_ok[i] = rbeat_s && (gnt_q == GW'(i));
    end
  end

  assign rd_last    = rbeat_s & rlast;
  assign rd_rdata   = rdata;
  assign wr_addr_ok = (wr_state_q == W_IDLE) && wr_req && !reset;
  assign wr_data_ok = bbeat_s;
  assign bus_err    = (rbeat_s && (rresp != 2'b00)) || (bbeat_s && (bresp != 2'b00));

  assign arid    = 4'(gnt_q);
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awid    = 4'h0;
  assign awaddr  = awaddr_q;
  assign awlen   = 4'h0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;
  assign wid     = 4'h0;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  assign unused_s = ^{rid, bid, len_ext_s[LEN_W+3:4]};

endmodule

// File: tb/tb_axi_sram_bridge_mc.sv
// Directed bench for axi_sram_bridge_mc: a round-robin instance is fully
// checked; a fixed-priority twin sees identical stimulus for arbitration checks.
module tb_axi_sram_bridge_mc;

  logic aclk = 1'b0;
  logic reset;
  logic [1:0]  rd_req;
  logic [63:0] rd_addr;
  logic [7:0]  rd_len;
  logic        wr_req;
  logic [31:0] wr_addr, wr_wdata;
  logic [1:0]  wr_size;
  logic [3:0]  wr_wstrb;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic [1:0]  rd_addr_ok, rd_data_ok;
  logic        rd_last, wr_addr_ok, wr_data_ok, bus_err;
  logic [31:0] rd_rdata, araddr, awaddr, wdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;

  logic [1:0]  f_rd_addr_ok, unused_f_rd_data_ok;
  logic        unused_f_rd_last, unused_f_wr_addr_ok, unused_f_wr_data_ok, unused_f_bus_err;
  logic [31:0] unused_f_rd_rdata, unused_f_araddr, unused_f_awaddr, unused_f_wdata;
  logic [3:0]  unused_f_arid, unused_f_arlen, unused_f_arcache, unused_f_awid;
  logic [3:0]  unused_f_awlen, unused_f_awcache, unused_f_wid, unused_f_wstrb;
  logic [2:0]  unused_f_arsize, unused_f_arprot, unused_f_awsize, unused_f_awprot;
  logic [1:0]  unused_f_arburst, unused_f_arlock, unused_f_awburst, unused_f_awlock;
  logic        unused_f_arvalid, unused_f_rready, unused_f_awvalid, unused_f_wvalid;
  logic        unused_f_wlast, unused_f_bready;

  int npass = 0;
  int ntot  = 0;

  always #5 aclk = ~aclk;

  axi_sram_bridge_mc #(.NCH(2), .LEN_W(4), .RR(1)) dut (
    .aclk(aclk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_addr_ok(rd_addr_ok), .rd_data_ok(rd_data_ok), .rd_last(rd_last), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_wstrb(wr_wstrb),
    .wr_wdata(wr_wdata), .wr_addr_ok(wr_addr_ok), .wr_data_ok(wr_data_ok), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_sram_bridge_mc #(.NCH(2), .LEN_W(4), .RR(0)) dut_fp (
    .aclk(aclk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_addr_ok(f_rd_addr_ok), .rd_data_ok(unused_f_rd_data_ok), .rd_last(unused_f_rd_last),
    .rd_rdata(unused_f_rd_rdata), .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_wstrb(wr_wstrb), .wr_wdata(wr_wdata), .wr_addr_ok(unused_f_wr_addr_ok),
    .wr_data_ok(unused_f_wr_data_ok), .bus_err(unused_f_bus_err),
    .arid(unused_f_arid), .araddr(unused_f_araddr), .arlen(unused_f_arlen),
    .arsize(unused_f_arsize), .arburst(unused_f_arburst), .arlock(unused_f_arlock),
    .arcache(unused_f_arcache), .arprot(unused_f_arprot), .arvalid(unused_f_arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(unused_f_rready),
    .awid(unused_f_awid), .awaddr(unused_f_awaddr), .awlen(unused_f_awlen),
    .awsize(unused_f_awsize), .awburst(unused_f_awburst), .awlock(unused_f_awlock),
    .awcache(unused_f_awcache), .awprot(unused_f_awprot), .awvalid(unused_f_awvalid),
    .awready(awready), .wid(unused_f_wid), .wdata(unused_f_wdata), .wstrb(unused_f_wstrb),
    .wlast(unused_f_wlast), .wvalid(unused_f_wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(unused_f_bready)
  );

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    logic [37:0] exp_c;
    logic [37:0] got_c;
    exp_c = {2'b01, 2'b01, 2'b00, 2'b00, 4'h0, 4'h0, 3'd0, 3'd0, 3'd2, 4'h0, 1'b1, 4'h0, 4'h0};
    reset = 1'b1;
    nxt(); nxt(); settle();
    ntot++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) $display("FAIL rst_valids: got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); else npass++;
    ntot++; if ({araddr, awaddr, wdata} !== 96'h0) $display("FAIL rst_regs: got %h want 0", {araddr, awaddr, wdata}); else npass++;
    ntot++; if ({rd_addr_ok, rd_data_ok, wr_addr_ok, wr_data_ok, bus_err} !== 7'b0) $display("FAIL rst_oks: got %b want 0", {rd_addr_ok, rd_data_ok, wr_addr_ok, wr_data_ok, bus_err}); else npass++;
    nxt(); reset = 1'b0; settle();
    got_c = {arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot, arsize, awlen, wlast, awid, wid};
    ntot++; if (got_c !== exp_c) $display("FAIL axi_consts: got %h want %h", got_c, exp_c); else npass++;
  endtask

  task automatic test_single_read();
    nxt(); rd_req = 2'b01; rd_addr = {32'h0, 32'h1FC0_0000}; rd_len = 8'h00; settle();
    ntot++; if (rd_addr_ok !== 2'b01) $display("FAIL sr_addr_ok: got %b want 01", rd_addr_ok); else npass++;
    for (int k = 0; k < 3; k++) begin
      nxt(); rd_req = 2'b00; arready = (k == 2); settle();
      ntot++; if ({arvalid, araddr, arlen, arid} !== {1'b1, 32'h1FC0_0000, 4'h0, 4'h0}) $display("FAIL sr_ar_hold%0d: got v=%b a=%h len=%h id=%h want v=1 a=1fc00000 len=0 id=0", k, arvalid, araddr, arlen, arid); else npass++;
    end
    nxt(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h3C1D_0001; settle();
    ntot++; if ({rready, arvalid, rd_data_ok, rd_last} !== 5'b10011) $display("FAIL sr_beat: got rready=%b arvalid=%b ok=%b last=%b want 1 0 01 1", rready, arvalid, rd_data_ok, rd_last); else npass++;
    ntot++; if (rd_rdata !== 32'h3C1D_0001) $display("FAIL sr_rdata: got %h want 3c1d0001", rd_rdata); else npass++;
    nxt(); rvalid = 1'b0; rlast = 1'b0; settle();
    ntot++; if ({rready, rd_data_ok} !== 3'b000) $display("FAIL sr_done: got rready=%b ok=%b want 0 00", rready, rd_data_ok); else npass++;
  endtask

  task automatic test_burst();
    logic [6:0] pat;
    int beat;
    int pulses;
    pat = 7'b1100101;
    beat = 0;
    pulses = 0;
    nxt(); rd_req = 2'b10; rd_addr = {32'h0000_1000, 32'h0}; rd_len = {4'd3, 4'd0}; settle();
    ntot++; if (rd_addr_ok !== 2'b10) $display("FAIL bu_addr_ok: got %b want 10", rd_addr_ok); else npass++;
    nxt(); rd_req = 2'b00; arready = 1'b1; settle();
    ntot++; if ({arvalid, araddr, arlen, arid} !== {1'b1, 32'h0000_1000, 4'd3, 4'd1}) $display("FAIL bu_ar: got v=%b a=%h len=%h id=%h want 1 00001000 3 1", arvalid, araddr, arlen, arid); else npass++;
    for (int k = 0; k < 7; k++) begin
      nxt(); arready = 1'b0; rvalid = pat[k]; rlast = (k == 6); rdata = 32'hB000_0000 + beat; settle();
      if (rd_data_ok[1]) pulses++;
      ntot++; if (rd_data_ok !== (pat[k] ? 2'b10 : 2'b00)) $display("FAIL bu_ok_c%0d: got %b want %b", k, rd_data_ok, pat[k] ? 2'b10 : 2'b00); else npass++;
      if (pat[k]) begin
        ntot++; if ({rd_last, rd_rdata} !== {(beat == 3), 32'hB000_0000 + beat}) $display("FAIL bu_beat%0d: got last=%b d=%h want last=%b d=%h", beat, rd_last, rd_rdata, (beat == 3), 32'hB000_0000 + beat); else npass++;
        beat++;
      end
    end
    nxt(); rvalid = 1'b0; rlast = 1'b0; settle();
    ntot++; if (pulses !== 4) $display("FAIL bu_pulses: got %0d want 4", pulses); else npass++;
    ntot++; if (rready !== 1'b0) $display("FAIL bu_rready_end: got %b want 0", rready); else npass++;
  endtask

  task automatic test_arbitration();
    int g_rr[4];
    int g_fp[4];
    int n_rr;
    int n_fp;
    n_rr = 0;
    n_fp = 0;
    for (int k = 0; k < 12; k++) begin
      nxt(); rd_req = 2'b11; rd_addr = {32'h0000_4000, 32'h0000_3000}; rd_len = 8'h00;
      arready = 1'b1; rvalid = rready; rlast = rready; rdata = 32'h0000_00A0 + k; settle();
      if (rd_addr_ok != 2'b00 && n_rr < 4) begin g_rr[n_rr] = rd_addr_ok[1] ? 1 : 0; n_rr++; end
      if (f_rd_addr_ok != 2'b00 && n_fp < 4) begin g_fp[n_fp] = f_rd_addr_ok[1] ? 1 : 0; n_fp++; end
    end
    nxt(); rd_req = 2'b00; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; settle();
    ntot++; if ({n_rr, n_fp} !== {32'd4, 32'd4}) $display("FAIL arb_count: got rr=%0d fp=%0d want 4 4", n_rr, n_fp); else npass++;
    for (int i = 0; i < n_rr; i++) begin
      ntot++; if (g_rr[i] !== (i % 2)) $display("FAIL rr_grant%0d: got %0d want %0d", i, g_rr[i], i % 2); else npass++;
    end
    for (int i = 0; i < n_fp; i++) begin
      ntot++; if (g_fp[i] !== 0) $display("FAIL fp_grant%0d: got %0d want 0", i, g_fp[i]); else npass++;
    end
    ntot++; if ({rready, arvalid} !== 2'b00) $display("FAIL arb_idle: got rready=%b arvalid=%b want 0 0", rready, arvalid); else npass++;
  endtask

  task automatic test_hazard();
    nxt(); wr_req = 1'b1; wr_addr = 32'h0000_2004; wr_size = 2'd0; wr_wstrb = 4'b0001; wr_wdata = 32'h0000_00AB; settle();
    ntot++; if (wr_addr_ok !== 1'b1) $display("FAIL hz_wr_addr_ok: got %b want 1", wr_addr_ok); else npass++;
    nxt(); wr_req = 1'b0; rd_req = 2'b10; rd_addr = {32'h0000_2008, 32'h0000_5000}; rd_len = 8'h00; settle();
    ntot++; if ({awvalid, wvalid, awaddr, awsize, wstrb, wdata} !== {1'b1, 1'b1, 32'h0000_2004, 3'd0, 4'b0001, 32'h0000_00AB}) $display("FAIL hz_aw_w: got %b %b %h %h %b %h want 1 1 00002004 0 0001 000000ab", awvalid, wvalid, awaddr, awsize, wstrb, wdata); else npass++;
    ntot++; if (rd_addr_ok !== 2'b00) $display("FAIL hz_blocked1: got %b want 00", rd_addr_ok); else npass++;
    nxt(); rd_req = 2'b11; settle();
    ntot++; if (rd_addr_ok !== 2'b01) $display("FAIL hz_other_page: got %b want 01", rd_addr_ok); else npass++;
    nxt(); rd_req = 2'b10; arready = 1'b1; settle();
    ntot++; if ({arvalid, araddr, rd_addr_ok} !== {1'b1, 32'h0000_5000, 2'b00}) $display("FAIL hz_ar5000: got v=%b a=%h ok=%b want 1 00005000 00", arvalid, araddr, rd_addr_ok); else npass++;
    nxt(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_AAAA; awready = 1'b1; wready = 1'b1; settle();
    ntot++; if ({rd_data_ok, rd_rdata, awvalid, wvalid} !== {2'b01, 32'h5555_AAAA, 1'b1, 1'b1}) $display("FAIL hz_concurrent: got ok=%b d=%h aw=%b w=%b want 01 5555aaaa 1 1", rd_data_ok, rd_rdata, awvalid, wvalid); else npass++;
    nxt(); rvalid = 1'b0; rlast = 1'b0; awready = 1'b0; wready = 1'b0; settle();
    ntot++; if ({bready, awvalid, wvalid, rd_addr_ok} !== 5'b10000) $display("FAIL hz_resp_wait: got b=%b aw=%b w=%b ok=%b want 1 0 0 00", bready, awvalid, wvalid, rd_addr_ok); else npass++;
    nxt(); bvalid = 1'b1; bresp = 2'b00; settle();
    ntot++; if ({wr_data_ok, bus_err, rd_addr_ok} !== 4'b1000) $display("FAIL hz_bresp: got wok=%b err=%b ok=%b want 1 0 00", wr_data_ok, bus_err, rd_addr_ok); else npass++;
    nxt(); bvalid = 1'b0; settle();
    ntot++; if (rd_addr_ok !== 2'b10) $display("FAIL hz_released: got %b want 10", rd_addr_ok); else npass++;
    nxt(); rd_req = 2'b00; arready = 1'b1; settle();
    ntot++; if ({araddr, arid} !== {32'h0000_2008, 4'd1}) $display("FAIL hz_ar2008: got a=%h id=%h want 00002008 1", araddr, arid); else npass++;
    nxt(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1111_2222; settle();
    ntot++; if ({rd_data_ok, rd_rdata} !== {2'b10, 32'h1111_2222}) $display("FAIL hz_beat1: got ok=%b d=%h want 10 11112222", rd_data_ok, rd_rdata); else npass++;
    nxt(); rvalid = 1'b0; rlast = 1'b0; settle();
  endtask

  task automatic test_write_err();
    nxt(); wr_req = 1'b1; wr_addr = 32'h0000_6000; wr_size = 2'd2; wr_wstrb = 4'hF; wr_wdata = 32'hDEAD_BEEF; settle();
    ntot++; if (wr_addr_ok !== 1'b1) $display("FAIL we_addr_ok: got %b want 1", wr_addr_ok); else npass++;
    nxt(); wr_req = 1'b0; awready = 1'b1; settle();
    ntot++; if ({awvalid, wvalid, awsize} !== {1'b1, 1'b1, 3'd2}) $display("FAIL we_send: got aw=%b w=%b sz=%h want 1 1 2", awvalid, wvalid, awsize); else npass++;
    nxt(); awready = 1'b0; settle();
    ntot++; if ({awvalid, wvalid} !== 2'b01) $display("FAIL we_aw_drop: got aw=%b w=%b want 0 1", awvalid, wvalid); else npass++;
    nxt(); wready = 1'b1; settle();
    ntot++; if ({awvalid, wvalid, bready} !== 3'b010) $display("FAIL we_w_hold: got aw=%b w=%b b=%b want 0 1 0", awvalid, wvalid, bready); else npass++;
    nxt(); wready = 1'b0; bvalid = 1'b1; bresp = 2'b10; settle();
    ntot++; if ({wvalid, bready, wr_data_ok, bus_err} !== 4'b0111) $display("FAIL we_bresp_err: got w=%b b=%b wok=%b err=%b want 0 1 1 1", wvalid, bready, wr_data_ok, bus_err); else npass++;
    nxt(); bvalid = 1'b0; bresp = 2'b00; settle();
    ntot++; if ({bready, wr_data_ok, bus_err} !== 3'b000) $display("FAIL we_done: got b=%b wok=%b err=%b want 0 0 0", bready, wr_data_ok, bus_err); else npass++;
  endtask

  task automatic test_reset_mid();
    nxt(); rd_req = 2'b01; rd_addr = {32'h0, 32'h0000_7000}; rd_len = {4'd0, 4'd3}; settle();
    ntot++; if (rd_addr_ok !== 2'b01) $display("FAIL rm_addr_ok: got %b want 01", rd_addr_ok); else npass++;
    nxt(); rd_req = 2'b00; arready = 1'b1; settle();
    nxt(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0001; settle();
    ntot++; if ({rd_data_ok, rd_last} !== 3'b010) $display("FAIL rm_beat1: got ok=%b last=%b want 01 0", rd_data_ok, rd_last); else npass++;
    nxt(); reset = 1'b1; rdata = 32'h0000_0002; settle();
    nxt(); reset = 1'b0; rdata = 32'h0000_0003; settle();
    ntot++; if ({rready, arvalid, rd_data_ok} !== 4'b0000) $display("FAIL rm_abandon: got rready=%b arvalid=%b ok=%b want 0 0 00", rready, arvalid, rd_data_ok); else npass++;
    nxt(); rvalid = 1'b0; rd_req = 2'b10; rd_addr = {32'h0000_8000, 32'h0}; rd_len = 8'h00; settle();
    ntot++; if (rd_addr_ok !== 2'b10) $display("FAIL rm_fresh_ok: got %b want 10", rd_addr_ok); else npass++;
    nxt(); rd_req = 2'b00; arready = 1'b1; settle();
    ntot++; if ({arvalid, araddr} !== {1'b1, 32'h0000_8000}) $display("FAIL rm_fresh_ar: got v=%b a=%h want 1 00008000", arvalid, araddr); else npass++;
    nxt(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hCAFE_0008; settle();
    ntot++; if ({rd_data_ok, rd_last, rd_rdata} !== {2'b10, 1'b1, 32'hCAFE_0008}) $display("FAIL rm_fresh_beat: got ok=%b last=%b d=%h want 10 1 cafe0008", rd_data_ok, rd_last, rd_rdata); else npass++;
    nxt(); rvalid = 1'b0; rlast = 1'b0; settle();
  endtask

  initial begin
    reset = 1'b1; rd_req = 2'b00; rd_addr = 64'h0; rd_len = 8'h00;
    wr_req = 1'b0; wr_addr = 32'h0; wr_size = 2'd0; wr_wstrb = 4'h0; wr_wdata = 32'h0;
    arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'h0; bresp = 2'b00; bvalid = 1'b0;
    test_reset();
    test_single_read();
    test_burst();
    test_arbitration();
    test_hazard();
    test_write_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
